// File: rtl/accel_pkg.sv
// Shared types for the fetch/decode accelerator path.
package accel_pkg;

  localparam int INSTR_W = 16;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY
  } buf_state_t;

endpackage

// File: rtl/instr_buffer_ram.sv
// DEPTH x DATA_W register array: synchronous write port, combinational read port.
module instr_buffer_ram
  import accel_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = INSTR_W
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents need no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_buffer.sv
// Instruction FIFO between fetcher and decoder, replaying entries with a start/ready handshake.
// Build option INSTR_BUFFER_STATS_EN adds occupancy and sticky overflow outputs.
//
// state     | meaning
// IDLE      | waiting for a stored entry and an idle decoder
// ISSUE     | out_start high for this single cycle
// WAIT_BUSY | waiting for the decoder to drop out_ready
module instr_buffer
  import accel_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_start,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_start,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready
`ifdef INSTR_BUFFER_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  buf_state_t        state_q, state_d;
  logic              out_start_q, out_start_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] rd_data;
  logic              push;
  logic              pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign push      = in_start && in_ready;
  assign out_start = out_start_q;
  assign out_data  = out_data_q;

  instr_buffer_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    out_start_d = 1'b0;
    out_data_d  = out_data_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        // Uses the registered count, so an entry pushed this edge is not yet poppable.
        if ((count_q != '0) && out_ready) begin
          pop         = 1'b1;
          out_start_d = 1'b1;
          out_data_d  = rd_data;
          state_d     = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!out_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      out_start_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      out_start_q <= out_start_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef INSTR_BUFFER_STATS_EN
  logic overflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (in_start & ~in_ready);
    end
  end

  assign occupancy = count_q;
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_instr_buffer.sv
// Scoreboard bench for instr_buffer: stimulus queues expected instructions, a monitor checks each out_start.
module tb_instr_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_start = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_start;
  logic [15:0] out_data;
  logic        out_ready;
`ifdef INSTR_BUFFER_STATS_EN
  logic [3:0]  occupancy;
  logic        overflow;
`endif

  logic        dec_ready_r = 1'b1;
  logic        dec_hold = 1'b0;
  int          busy = 0;
  logic        prev_start = 1'b0;
  int          n_starts = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];

  assign out_ready = dec_ready_r & ~dec_hold;

  always #5 clk = ~clk;

  instr_buffer #(.DEPTH(8), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_start  (in_start),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_start (out_start),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef INSTR_BUFFER_STATS_EN
    ,
    .occupancy (occupancy),
    .overflow  (overflow)
`endif
  );

  // Decoder model: ready drops right after start is seen and stays low two cycles.
  always @(negedge clk) begin
    if (reset) busy = 0;
    else if (out_start) busy = 2;
    else if (busy > 0) busy = busy - 1;
    dec_ready_r = (busy == 0);
  end

  // Monitor: every out_start must carry the oldest outstanding instruction.
  always @(negedge clk) begin
    if (!reset && out_start) begin
      n_starts++;
      checks++;
      if (prev_start) begin
        failures++;
        $display("FAIL pulse_width out_start high two cycles running, required one cycle");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start actual data=%h required no out_start", out_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_data actual=%h required=%h", out_data, e);
        end
      end
    end
    prev_start = reset ? 1'b0 : out_start;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] d, input bit accept);
    in_start = 1'b1;
    in_data  = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain timeout, %0d entries still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_in_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s in_ready timeout actual=0 required=1", name);
    end
  endtask

  initial begin
    int starts0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_start", out_start, 0);
    chk("rst_out_data", out_data, 16'h0000);
`ifdef INSTR_BUFFER_STATS_EN
    chk("rst_occupancy", occupancy, 0);
    chk("rst_overflow", overflow, 0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single push: two-cycle latency, one-cycle pulse.
    push(16'hA5C3, 1);
    chk("t1_in_ready", in_ready, 1);
    chk("t1_no_early_start", out_start, 0);
    @(negedge clk);
    chk("t1_start", out_start, 1);
    @(negedge clk);
    chk("t1_pulse_end", out_start, 0);
    wait_drain("t1");
    chk("t1_data_hold", out_data, 16'hA5C3);

    // Fill with decoder held busy, then overflow attempt.
    dec_hold = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      push(16'(i), 1);
      if (i == 7) chk("t2_ready_at_7", in_ready, 1);
      if (i == 8) chk("t2_full", in_ready, 0);
    end
    push(16'hDEAD, 0);
    repeat (2) @(negedge clk);
    chk("t3_still_full", in_ready, 0);
`ifdef INSTR_BUFFER_STATS_EN
    chk("t3_occupancy", occupancy, 8);
    chk("t3_overflow", overflow, 1);
`endif
    dec_hold = 1'b0;
    wait_drain("t2");
    chk("t2_ready_after_drain", in_ready, 1);
`ifdef INSTR_BUFFER_STATS_EN
    chk("t3_overflow_sticky", overflow, 1);
    chk("t2_occupancy_empty", occupancy, 0);
`endif

    // Interleaved traffic, 20 instructions, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      wait_in_ready("t4");
      push(16'h1000 + 16'(i), 1);
`ifdef INSTR_BUFFER_STATS_EN
      if (occupancy > 8) chk("t4_occupancy_bound", occupancy, 8);
`endif
      if (i % 3 == 0) @(negedge clk);
    end
    wait_drain("t4");

    // Push and issue on the same edge with three entries held.
    dec_hold = 1'b1;
    @(negedge clk);
    push(16'h2001, 1);
    push(16'h2002, 1);
    push(16'h2003, 1);
    dec_hold = 1'b0;
    in_start = 1'b1;
    in_data  = 16'h2004;
    exp_q.push_back(16'h2004);
    @(negedge clk);
    in_start = 1'b0;
    dec_hold = 1'b1;
    chk("t5_issue", out_start, 1);
    chk("t5_in_ready", in_ready, 1);
`ifdef INSTR_BUFFER_STATS_EN
    chk("t5_occupancy", occupancy, 3);
`endif
    for (int i = 5; i <= 9; i++) begin
      push(16'h2000 + 16'(i), 1);
      if (i == 8) chk("t5_ready_at_7", in_ready, 1);
      if (i == 9) chk("t5_full_at_8", in_ready, 0);
    end
    dec_hold = 1'b0;
    wait_drain("t5");

    // Async reset during ISSUE with five entries held.
    dec_hold = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) push(16'h3000 + 16'(i), 1);
    dec_hold = 1'b0;
    @(negedge clk);
    chk("t6_issue", out_start, 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_start_dropped", out_start, 0);
    chk("t6_in_ready", in_ready, 1);
`ifdef INSTR_BUFFER_STATS_EN
    chk("t6_occupancy", occupancy, 0);
    chk("t6_overflow_cleared", overflow, 0);
`endif
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    starts0 = n_starts;
    repeat (10) @(negedge clk);
    chk("t6_no_start_after_reset", n_starts, starts0);
    push(16'h3100, 1);
    wait_drain("t6");
    chk("t6_one_start_after_push", n_starts, starts0 + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
